// File: rtl/serial_signed_subtractor_pkg.sv
// Shared types and constants for the bit-serial signed subtractor.
package serial_signed_subtractor_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam int unsigned DefaultWidth = 8;

    // Counter must reach WIDTH-1; one spare bit keeps the compare simple.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_signed_subtractor_if.sv
// Start/done request bus between the ALU datapath and the serial subtractor.
interface serial_signed_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    modport master (
        output start, a, b, borrow_in,
        input  busy, done, diff, borrow_out, overflow
    );

    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, diff, borrow_out, overflow
    );
endinterface

// File: rtl/serial_signed_subtractor_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow out.
module serial_signed_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end
endmodule

// File: rtl/serial_signed_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
module serial_signed_subtractor
    import serial_signed_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic                        clk,
    input  logic                        rst_n,
    serial_signed_subtractor_if.slave   bus
);
    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             cell_d, cell_bout;

    serial_signed_subtractor_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = bus.borrow_in;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                br_d  = cell_bout;
                res_d = {cell_d, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastBit) begin
                    // On the last bit a_q[0]/b_q[0] are the captured operand signs.
                    diff_d  = {cell_d, res_q[WIDTH-1:1]};
                    bout_d  = cell_bout;
                    ovf_d   = (a_q[0] != b_q[0]) && (cell_d != a_q[0]);
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy       = (state_q == StShift);
    assign bus.done       = (state_q == StDone);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = bout_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_serial_signed_subtractor.sv
// Directed self-checking bench for the 8-bit serial signed subtractor.
module tb_serial_signed_subtractor;
    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    serial_signed_subtractor_if #(.WIDTH(8)) bus ();

    serial_signed_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launches one job from the current cycle; lat counts edges from the accepting edge
    // to done high (-1 if done never arrives within the budget).
    task automatic do_job(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                          output int lat);
        bus.start     = 1'b1;
        bus.a         = ta;
        bus.b         = tb;
        bus.borrow_in = tbin;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.a         = 8'hA5;
        bus.b         = 8'h5A;
        bus.borrow_in = 1'b1;
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.done) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.borrow_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
        else pass_cnt++;
        total_cnt++;
        if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done);
        else pass_cnt++;
        total_cnt++;
        if (bus.diff !== 8'h00) $display("FAIL reset_diff: got %h want 00", bus.diff);
        else pass_cnt++;
        total_cnt++;
        if (bus.borrow_out !== 1'b0) $display("FAIL reset_borrow: got %b want 0", bus.borrow_out);
        else pass_cnt++;
        total_cnt++;
        if (bus.overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", bus.overflow);
        else pass_cnt++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_arith();
        logic [7:0] va [6];
        logic [7:0] vb [6];
        logic       vbin [6];
        logic [7:0] ed [6];
        logic       eb [6];
        logic       eo [6];
        int lat;
        va = '{8'd64, 8'd100, 8'h9C, 8'hE2, 8'd5, 8'h80};
        vb = '{8'd50, 8'hCE, 8'd30, 8'hBA, 8'd5, 8'h01};
        vbin = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        ed = '{8'h0E, 8'h96, 8'h7E, 8'h28, 8'hFF, 8'h7F};
        eb = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        eo = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            do_job(va[i], vb[i], vbin[i], lat);
            total_cnt++;
            if (lat !== 9) $display("FAIL arith%0d_latency: got %0d want 9", i, lat);
            else pass_cnt++;
            total_cnt++;
            if (bus.diff !== ed[i]) $display("FAIL arith%0d_diff: got %h want %h", i, bus.diff, ed[i]);
            else pass_cnt++;
            total_cnt++;
            if (bus.borrow_out !== eb[i])
                $display("FAIL arith%0d_borrow: got %b want %b", i, bus.borrow_out, eb[i]);
            else pass_cnt++;
            total_cnt++;
            if (bus.overflow !== eo[i])
                $display("FAIL arith%0d_ovf: got %b want %b", i, bus.overflow, eo[i]);
            else pass_cnt++;
            total_cnt++;
            if (bus.busy !== 1'b0) $display("FAIL arith%0d_busy_at_done: got %b want 0", i, bus.busy);
            else pass_cnt++;
            @(posedge clk);
            #1;
            total_cnt++;
            if (bus.done !== 1'b0) $display("FAIL arith%0d_done_pulse: got %b want 0", i, bus.done);
            else pass_cnt++;
        end
    endtask

    // Previous result is 0x7F/ovf=1; it must hold while the new job shifts.
    task automatic test_mid_start();
        int lat;
        bus.start = 1'b1;
        bus.a = 8'd64;
        bus.b = 8'd50;
        bus.borrow_in = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 1;
        total_cnt++;
        if (bus.busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", bus.busy);
        else pass_cnt++;
        while (!bus.done && lat < 40) begin
            if (lat == 3) begin
                bus.start = 1'b1;
                bus.a = 8'd1;
                bus.b = 8'd2;
                bus.borrow_in = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (lat == 5) begin
                total_cnt++;
                if (bus.diff !== 8'h7F) $display("FAIL mid_hold_diff: got %h want 7f", bus.diff);
                else pass_cnt++;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
        total_cnt++;
        if (lat !== 9) $display("FAIL mid_latency: got %0d want 9", lat);
        else pass_cnt++;
        total_cnt++;
        if (bus.diff !== 8'h0E) $display("FAIL mid_diff: got %h want 0e", bus.diff);
        else pass_cnt++;
        total_cnt++;
        if (bus.overflow !== 1'b0) $display("FAIL mid_ovf: got %b want 0", bus.overflow);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL mid_idle: got busy=%b done=%b want 0/0", bus.busy, bus.done);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat;
        do_job(8'd100, 8'hCE, 1'b0, lat);
        total_cnt++;
        if (lat !== 9 || bus.diff !== 8'h96)
            $display("FAIL b2b_first: got lat=%0d diff=%h want 9/96", lat, bus.diff);
        else pass_cnt++;
        // done is high now, so this start is accepted in DONE.
        do_job(8'hE2, 8'hBA, 1'b0, lat);
        total_cnt++;
        if (lat !== 9) $display("FAIL b2b_latency: got %0d want 9", lat);
        else pass_cnt++;
        total_cnt++;
        if (bus.diff !== 8'h28 || bus.overflow !== 1'b0 || bus.borrow_out !== 1'b0)
            $display("FAIL b2b_result: got %h/%b/%b want 28/0/0",
                     bus.diff, bus.overflow, bus.borrow_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int seen;
        bus.start = 1'b1;
        bus.a = 8'd5;
        bus.b = 8'd5;
        bus.borrow_in = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL rstmid_ctrl: got busy=%b done=%b want 0/0", bus.busy, bus.done);
        else pass_cnt++;
        total_cnt++;
        if (bus.diff !== 8'h00 || bus.borrow_out !== 1'b0 || bus.overflow !== 1'b0)
            $display("FAIL rstmid_outputs: got %h/%b/%b want 00/0/0",
                     bus.diff, bus.borrow_out, bus.overflow);
        else pass_cnt++;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL rstmid_no_done: got %0d active cycles want 0", seen);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_arith();
        test_mid_start();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
